// File: rtl/ps2_matrix_pkg.sv
// Shared MSX keyboard definitions: matrix size, layout-entry bit positions,
// FSM state type and the built-in image of kbd_layout.mif used by the ROM build.
package ps2_matrix_pkg;

  localparam int KBD_ROWS   = 11;
  localparam int TBL_AW     = 9;

  // Layout entry: [7] valid, [6:3] row, [2:0] column
  localparam int LE_VALID   = 7;
  localparam int LE_ROW_MSB = 6;
  localparam int LE_ROW_LSB = 3;
  localparam int LE_COL_MSB = 2;
  localparam int LE_COL_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_APPLY  = 2'd2
  } state_e;

  // Contents of kbd_layout.mif, indexed by {extended, scan code}.
  // Unlisted codes are invalid (no MSX key).
  function automatic logic [7:0] kbd_layout_image(input logic [TBL_AW-1:0] addr);
    logic [7:0] e;
    e = 8'h00;
    case (addr)
      9'h016: e = 8'h81;  // 1        row0 col1
      9'h01E: e = 8'h82;  // 2        row0 col2
      9'h026: e = 8'h83;  // 3        row0 col3
      9'h025: e = 8'h84;  // 4        row0 col4
      9'h01C: e = 8'h96;  // A        row2 col6
      9'h012: e = 8'hB0;  // L-shift  row6 col0
      9'h005: e = 8'hB5;  // F1       row6 col5
      9'h076: e = 8'hBA;  // ESC      row7 col2
      9'h05A: e = 8'hBF;  // ENTER    row7 col7
      9'h029: e = 8'hC0;  // SPACE    row8 col0
      9'h175: e = 8'hC0;  // E0 75    row8 col0
      9'h16B: e = 8'hC4;  // E0 LEFT  row8 col4
      9'h070: e = 8'hCB;  // KP0      row9 col3
      9'h069: e = 8'hD4;  // KP1      row10 col4
      9'h07E: e = 8'hE0;  // SCROLL   row12: beyond the matrix, dropped
      default: e = 8'h00;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/ps2_matrix_tbl.sv
// 512x8 PS/2-to-MSX layout table, single port, registered read data.
// Build option KBD_TABLE_LOAD_EN: RAM written at runtime through we/wr_addr/din.
// Default build: ROM holding the kbd_layout.mif image; write port ignored.
module ps2_matrix_tbl
  import ps2_matrix_pkg::*;
#(
  parameter TBL_INIT = "kbd_layout.mif"
) (
  input  logic              clk21m,
  input  logic              we_i,
  input  logic [TBL_AW-1:0] wr_addr_i,
  input  logic [7:0]        din_i,
  input  logic [TBL_AW-1:0] rd_addr_i,
  output logic [7:0]        dout_o
);

  logic [7:0] dout_q;

`ifdef KBD_TABLE_LOAD_EN
  logic [7:0]        mem_q [0:(1<<TBL_AW)-1];
  logic [TBL_AW-1:0] addr;
  logic              unused_init;

  // One address port: a write steals it from the read for that cycle.
  assign addr        = we_i ? wr_addr_i : rd_addr_i;
  assign unused_init = ^TBL_INIT;

  // Synchronous write or registered read
  always_ff @(posedge clk21m) begin
    if (we_i) mem_q[addr] <= din_i;
    else      dout_q      <= mem_q[addr];
  end
`else
  localparam bit BUILTIN = (TBL_INIT == "kbd_layout.mif");
  logic unused_wr;

  assign unused_wr = ^{we_i, wr_addr_i, din_i};

  // Registered ROM read; an unknown image name yields an all-invalid table
  always_ff @(posedge clk21m) begin
    dout_q <= BUILTIN ? kbd_layout_image(rd_addr_i) : 8'h00;
  end
`endif

  assign dout_o = dout_q;

endmodule

// File: rtl/ps2_matrix.sv
// PS/2 key events -> MSX keyboard matrix (active-low rows) read by the PPI.
// Build option KBD_TABLE_LOAD_EN: layout table writable at runtime, and a
// table write during LOOKUP holds the FSM there for a re-read.
//
// Handshake: ps2_key_i[10] toggles once per event (no valid/ready); the event
// is taken on the edge where it differs from the previous sample. busy_o is
// high while an event is in LOOKUP or APPLY; one further event is buffered.
module ps2_matrix
  import ps2_matrix_pkg::*;
#(
  parameter     TBL_INIT = "kbd_layout.mif",
  parameter int ROWS     = KBD_ROWS
) (
  input  logic              clk21m,
  input  logic              reset,
  input  logic [10:0]       ps2_key_i,
  input  logic [3:0]        kb_row_i,
  output logic [7:0]        kb_data_o,
  input  logic              tbl_we_i,
  input  logic [TBL_AW-1:0] tbl_addr_i,
  input  logic [7:0]        tbl_din_i,
  output logic              busy_o,
  output state_e            state_o
);

  state_e      state_q, state_d;
  logic        armed_q;
  logic        prev_tgl_q;
  logic        pend_q, pend_d;
  logic [9:0]  pend_key_q, pend_key_d;   // {pressed, extended, code}
  logic [9:0]  cur_key_q, cur_key_d;
  logic [7:0]  matrix_q [ROWS];
  logic [7:0]  matrix_d [ROWS];
  logic [7:0]  kb_data_q, kb_data_d;

  logic        evt;
  logic        take;
  logic        tbl_wr;
  logic [7:0]  entry;
  logic [3:0]  ent_row;
  logic [2:0]  ent_col;
  logic        hit;

`ifdef KBD_TABLE_LOAD_EN
  assign tbl_wr = tbl_we_i;
`else
  assign tbl_wr = 1'b0;
`endif

  // armed_q is low for the first cycle after reset so the first toggle sample
  // only seeds prev_tgl_q and never counts as an event.
  assign evt = armed_q && (ps2_key_i[10] != prev_tgl_q);

  ps2_matrix_tbl #(
    .TBL_INIT (TBL_INIT)
  ) u_tbl (
    .clk21m    (clk21m),
    .we_i      (tbl_we_i),
    .wr_addr_i (tbl_addr_i),
    .din_i     (tbl_din_i),
    .rd_addr_i (cur_key_d[8:0]),
    .dout_o    (entry)
  );

  assign ent_row = entry[LE_ROW_MSB:LE_ROW_LSB];
  assign ent_col = entry[LE_COL_MSB:LE_COL_LSB];
  assign hit     = (state_q == ST_APPLY) && entry[LE_VALID];

  // Next state, event buffer and lookup key. Leaving APPLY with an event
  // waiting re-enters LOOKUP directly, so back-to-back events keep busy high.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_key_d = pend_key_q;
    cur_key_d  = cur_key_q;
    take       = 1'b0;
    case (state_q)
      ST_IDLE:   take = pend_q | evt;
      ST_LOOKUP: if (!tbl_wr) state_d = ST_APPLY;
      ST_APPLY: begin
        state_d = ST_IDLE;
        take    = pend_q | evt;
      end
      default:   state_d = ST_IDLE;
    endcase
    if (take) begin
      // Oldest first: the buffered event goes, a fresh one takes its slot
      state_d   = ST_LOOKUP;
      cur_key_d = pend_q ? pend_key_q : ps2_key_i[9:0];
      pend_d    = pend_q & evt;
      if (evt) pend_key_d = ps2_key_i[9:0];
    end else if (evt) begin
      // Single-entry buffer: a newer event replaces an older waiting one
      pend_d     = 1'b1;
      pend_key_d = ps2_key_i[9:0];
    end
  end

  // Matrix update in APPLY (rows beyond ROWS never match) and row readout
  always_comb begin
    matrix_d  = matrix_q;
    kb_data_d = 8'hFF;
    for (int r = 0; r < ROWS; r++) begin
      if (hit && ent_row == 4'(r)) matrix_d[r][ent_col] = ~cur_key_q[9];
      if (kb_row_i == 4'(r))       kb_data_d = matrix_q[r];
    end
  end

  // FSM state register
  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Toggle tracking and event buffer
  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      armed_q    <= 1'b0;
      prev_tgl_q <= 1'b0;
      pend_q     <= 1'b0;
      pend_key_q <= '0;
      cur_key_q  <= '0;
    end else begin
      armed_q    <= 1'b1;
      prev_tgl_q <= ps2_key_i[10];
      pend_q     <= pend_d;
      pend_key_q <= pend_key_d;
      cur_key_q  <= cur_key_d;
    end
  end

  // Key matrix (1 = released) and registered row output
  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++) matrix_q[r] <= 8'hFF;
      kb_data_q <= 8'hFF;
    end else begin
      matrix_q  <= matrix_d;
      kb_data_q <= kb_data_d;
    end
  end

  assign kb_data_o = kb_data_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign state_o   = state_q;

endmodule

// File: tb/tb_ps2_matrix.sv
// Bench for ps2_matrix: reference model keeps the set of held MSX keys and
// the layout table; reads are scored by a monitor from an expected queue.
module tb_ps2_matrix;
  import ps2_matrix_pkg::*;

  localparam int MROWS = 11;

  logic        clk21m = 1'b0;
  logic        reset  = 1'b1;
  logic [10:0] ps2_key_i  = '0;
  logic [3:0]  kb_row_i   = '0;
  logic [7:0]  kb_data_o;
  logic        tbl_we_i   = 1'b0;
  logic [8:0]  tbl_addr_i = '0;
  logic [7:0]  tbl_din_i  = '0;
  logic        busy_o;
  state_e      state_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  int          row_q[$];
  logic        rd_tag = 1'b0;
  logic        rd_vld = 1'b0;
  bit          tgl = 1'b0;
  logic [7:0]  layout [512];
  bit          down [16][8];
  logic [8:0]  keys[$];

  ps2_matrix dut (
    .clk21m     (clk21m),
    .reset      (reset),
    .ps2_key_i  (ps2_key_i),
    .kb_row_i   (kb_row_i),
    .kb_data_o  (kb_data_o),
    .tbl_we_i   (tbl_we_i),
    .tbl_addr_i (tbl_addr_i),
    .tbl_din_i  (tbl_din_i),
    .busy_o     (busy_o),
    .state_o    (state_o)
  );

  // ---------------- clock ----------------
  always #5 clk21m = ~clk21m;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- check / model ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic init_layout();
    for (int a = 0; a < 512; a++) layout[a] = 8'h00;
    layout[9'h016] = 8'h81; layout[9'h01E] = 8'h82;
    layout[9'h026] = 8'h83; layout[9'h025] = 8'h84;
    layout[9'h01C] = 8'h96; layout[9'h012] = 8'hB0;
    layout[9'h005] = 8'hB5; layout[9'h076] = 8'hBA;
    layout[9'h05A] = 8'hBF; layout[9'h029] = 8'hC0;
    layout[9'h175] = 8'hC0; layout[9'h16B] = 8'hC4;
    layout[9'h070] = 8'hCB; layout[9'h069] = 8'hD4;
    layout[9'h07E] = 8'hE0;
    keys = '{9'h016, 9'h01E, 9'h026, 9'h025, 9'h01C, 9'h012, 9'h005, 9'h076,
             9'h05A, 9'h029, 9'h175, 9'h16B, 9'h070, 9'h069, 9'h07E, 9'h00E};
  endtask

  task automatic model_clear();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 8; c++) down[r][c] = 1'b0;
  endtask

  function automatic logic [7:0] ref_row(input int r);
    logic [7:0] v;
    v = 8'hFF;
    if (r < MROWS)
      for (int c = 0; c < 8; c++) if (down[r][c]) v[c] = 1'b0;
    return v;
  endfunction

  task automatic ref_event(input bit press, input logic [8:0] addr);
    logic [7:0] e;
    int row, col;
    e   = layout[addr];
    row = int'(e[6:3]);
    col = int'(e[2:0]);
    if (e[7] && row < MROWS) down[row][col] = press;
  endtask

  // ---------------- drivers ----------------
  task automatic load_table();
    for (int a = 0; a < 512; a++) begin
      @(negedge clk21m);
      tbl_we_i   = 1'b1;
      tbl_addr_i = 9'(a);
      tbl_din_i  = layout[a];
    end
    @(negedge clk21m);
    tbl_we_i = 1'b0;
  endtask

  task automatic send_key(input bit press, input logic [8:0] addr, input bit counts);
    @(negedge clk21m);
    tgl       = ~tgl;
    ps2_key_i = {tgl, press, addr};
    if (counts) ref_event(press, addr);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk21m);
    while (busy_o && n < 40) begin
      @(negedge clk21m);
      n++;
    end
    check({name, "_idle"}, 32'(busy_o), 32'd0);
  endtask

  task automatic read_row(input int r);
    @(negedge clk21m);
    kb_row_i = 4'(r);
    exp_q.push_back(ref_row(r));
    row_q.push_back(r);
    rd_tag = 1'b1;
    @(negedge clk21m);
    rd_tag = 1'b0;
  endtask

  task automatic read_all();
    for (int r = 0; r < 16; r++) read_row(r);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk21m) rd_vld <= rd_tag;

  always @(negedge clk21m) begin
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL kb_data: output %0h with empty expected queue", kb_data_o);
      end else begin
        check($sformatf("kb_data_row%0d", row_q.pop_front()), 32'(kb_data_o), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int bcnt;
    logic [8:0] a;
    bit p;

    init_layout();
    model_clear();

    // Reset state
    repeat (3) @(negedge clk21m);
    check("rst_kb_data", 32'(kb_data_o), 32'hFF);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_state", 32'(state_o), 32'(ST_IDLE));
    reset = 1'b0;
    load_table();
    repeat (2) @(negedge clk21m);
    check("post_rst_busy", 32'(busy_o), 32'd0);
    read_all();

    // Single press: latency to kb_data, then release
    @(negedge clk21m);
    kb_row_i = 4'd0;
    send_key(1'b1, 9'h016, 1'b1);
    repeat (3) @(negedge clk21m);
    check("lat_before", 32'(kb_data_o), 32'hFF);
    @(negedge clk21m);
    check("lat_after", 32'(kb_data_o), 32'hFD);
    wait_idle("press16");
    read_row(0);
    send_key(1'b0, 9'h016, 1'b1);
    wait_idle("rel16");
    read_row(0);

    // Extended code
    send_key(1'b1, 9'h175, 1'b1);
    wait_idle("ext175");
    read_row(8);
    read_row(0);
    send_key(1'b0, 9'h175, 1'b1);
    wait_idle("ext175_rel");
    read_row(8);

    // Two toggles one cycle apart
    @(negedge clk21m);
    kb_row_i = 4'd0;
    send_key(1'b1, 9'h016, 1'b1);
    send_key(1'b1, 9'h01E, 1'b1);
    bcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk21m);
      if (busy_o) bcnt++;
      if (i == 4) check("burst_kb_mid", 32'(kb_data_o), 32'hFD);
      if (i == 5) check("burst_kb_end", 32'(kb_data_o), 32'hF9);
    end
    check("burst_busy_cycles", 32'(bcnt), 32'd4);
    read_row(0);
    send_key(1'b0, 9'h016, 1'b1);
    wait_idle("burst_rel1");
    send_key(1'b0, 9'h01E, 1'b1);
    wait_idle("burst_rel2");
    read_row(0);

    // Four toggles in a row: third is overwritten by the fourth
    send_key(1'b1, 9'h016, 1'b1);
    send_key(1'b1, 9'h01E, 1'b1);
    send_key(1'b1, 9'h026, 1'b0);
    send_key(1'b1, 9'h025, 1'b1);
    wait_idle("overwrite");
    read_row(0);
    foreach (keys[k]) begin
      if (k < 4) begin
        send_key(1'b0, keys[k], 1'b1);
        wait_idle("overwrite_rel");
      end
    end
    read_row(0);

    // Idempotent press
    send_key(1'b1, 9'h016, 1'b1);
    wait_idle("idem1");
    send_key(1'b1, 9'h016, 1'b1);
    wait_idle("idem2");
    read_row(0);
    send_key(1'b0, 9'h016, 1'b1);
    wait_idle("idem_rel");

    // Invalid entry and row beyond the matrix
    send_key(1'b1, 9'h00E, 1'b1);
    wait_idle("invalid");
    read_all();
    send_key(1'b1, 9'h07E, 1'b1);
    wait_idle("row12");
    read_all();

    // Randomised events
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) a = 9'($urandom_range(0, 511));
      else a = keys[$urandom_range(0, keys.size() - 1)];
      p = 1'($urandom_range(0, 1));
      send_key(p, a, 1'b1);
      wait_idle("rand");
      read_row(int'(layout[a][6:3]));
      read_row($urandom_range(0, 15));
    end
    read_all();

    // Reset during LOOKUP of a press
    send_key(1'b1, 9'h01C, 1'b1);
    @(negedge clk21m);
    check("mid_state", 32'(state_o), 32'(ST_LOOKUP));
    reset = 1'b1;
    model_clear();
    @(negedge clk21m);
    check("mid_rst_kb_data", 32'(kb_data_o), 32'hFF);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk21m);
    reset = 1'b0;
    repeat (5) @(negedge clk21m);
    check("no_replay_busy", 32'(busy_o), 32'd0);
    read_all();

    // Drain scoreboard
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk21m);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
